// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter.
//   tx_state_e   - transmitter FSM states
//   PAR_*        - parity-mode encodings for the PARITY parameter
//   parity_bit() - parity bit for a zero-extended data word
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Data must be zero-extended to 9 bits so padding adds no ones.
    function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
        logic ones_odd;
        ones_odd = ^data;
        return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO.
//   clk_i, rst_i         - clock, synchronous active-high reset
//   wr_en_i, wr_data_i   - push request and data (ignored when full)
//   rd_en_i, rd_data_o   - pop request; rd_data_o always shows the head entry
//   full_o, empty_o      - occupancy flags
//   level_o              - number of entries held
module uart_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned LevelW = AddrW + 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              do_wr;
    logic              do_rd;

    assign full_o    = (level_q == LevelW'(Depth));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Full blocks a write even when a pop happens in the same cycle.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // Depth is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter with an input FIFO.
//   sys_clk, sys_rst    - clock, synchronous active-high reset
//   in_data, in_valid   - producer word and strobe; accepted when in_ready is high
//   in_ready            - FIFO not full
//   tx                  - registered serial line, idle high
//   busy                - frame on the line or words queued
//   fifo_level          - FIFO occupancy
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 5208,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CntW = $clog2(CLK_DIV);

    tx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 frame_q;

    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] head;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;

    uart_sync_fifo #(
        .Width (DATA_BITS),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .wr_en_i   (in_valid),
        .wr_data_i (in_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    // frame_q covers the cycle where tx still shows the last stop bit after the FSM idles.
    assign busy     = (state_q != StIdle) || frame_q || !fifo_empty;

    assign bit_end   = (cnt_q == CntW'(CLK_DIV - 1));
    assign last_data = (bit_idx_q == 4'(DATA_BITS - 1));
    assign last_stop = (bit_idx_q == 4'(STOP_BITS - 1));

    // tx_d is the line value for the current state; registering it delays the
    // whole frame by one cycle uniformly, so every bit still spans CLK_DIV cycles.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop       = 1'b0;
        tx_d      = 1'b1;

        if (state_q == StIdle || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (last_data) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? StStop : StParity;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                tx_d = par_q;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (last_stop) begin
                        bit_idx_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Capturing the word at pop time isolates the frame from later FIFO traffic.
        if (pop) begin
            shift_d = head;
            par_d   = parity_bit(9'(head), PARITY);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            frame_q   <= (state_q != StIdle);
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg with CLK_DIV = 4.
// Five instances cover no parity, even, odd, two stop bits and 7 data bits.
module tb_uart_tx_cfg;

    localparam int NDut   = 5;
    localparam int ClkDiv = 4;
    localparam int NVec   = 10;

    typedef struct {
        int          dut;
        logic [8:0]  data;
        logic [15:0] bits;      // line bits in transmit order, bit 0 = start bit
        int          len;
        bit          immediate; // start bit must follow the previous frame with no gap
    } frame_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [8:0] din [NDut];
    logic       vld [NDut];
    logic       rdy [NDut];
    logic       txw [NDut];
    logic       bsy [NDut];
    logic [2:0] lvl [NDut];

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    frame_t vec [NVec];

    always #5 sys_clk = ~sys_clk;

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_plain (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(din[0][7:0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .fifo_level(lvl[0]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(din[1][7:0]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .fifo_level(lvl[1]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(din[2][7:0]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]), .fifo_level(lvl[2]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(din[3][7:0]), .in_valid(vld[3]),
        .in_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]), .fifo_level(lvl[3]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d7 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(din[4][6:0]), .in_valid(vld[4]),
        .in_ready(rdy[4]), .tx(txw[4]), .busy(bsy[4]), .fifo_level(lvl[4]));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Offer one word on the next negedge; the bench decides acceptance from its own model.
    task automatic drive_write(input int d, input logic [8:0] data, input logic exp_ready,
                               input frame_t f);
        @(negedge sys_clk);
        vld[d] = 1'b1;
        din[d] = data;
        check($sformatf("dut%0d in_ready", d), 16'(rdy[d]), 16'(exp_ready));
        if (exp_ready) exp_q.push_back(f);
    endtask

    // Drop valid and scramble in_data to show accepted words are unaffected.
    task automatic drive_idle(input int d);
        @(negedge sys_clk);
        vld[d] = 1'b0;
        din[d] = 9'($urandom);
    endtask

    task automatic check_frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_t f;
            int     waited;
            logic   got;
            if (exp_q.size() == 0) begin
                check("scoreboard underflow", 16'd1, 16'd0);
                return;
            end
            f = exp_q.pop_front();
            waited = 0;
            do begin
                @(negedge sys_clk);
                waited++;
            end while (txw[f.dut] !== 1'b0 && waited < 200);
            check($sformatf("dut%0d start of %0h seen", f.dut, f.data), 16'(txw[f.dut]), 16'd0);
            if (txw[f.dut] !== 1'b0) return;
            if (f.immediate) begin
                check($sformatf("dut%0d %0h start gap", f.dut, f.data), 16'(waited), 16'd1);
            end
            for (int j = 0; j < f.len; j++) begin
                got = f.bits[j];
                for (int c = 0; c < ClkDiv; c++) begin
                    if (j != 0 || c != 0) @(negedge sys_clk);
                    if (txw[f.dut] !== f.bits[j]) got = txw[f.dut];
                    if (j == 2 && c == 0) begin
                        check($sformatf("dut%0d busy mid-frame", f.dut), 16'(bsy[f.dut]), 16'd1);
                    end
                end
                check($sformatf("dut%0d data %0h line bit %0d", f.dut, f.data, j),
                      16'(got), 16'(f.bits[j]));
            end
        end
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        while (bsy[d] !== 1'b0 && w < 8) begin
            @(negedge sys_clk);
            w++;
        end
        check($sformatf("dut%0d busy falls", d), 16'(bsy[d]), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         i;
        int         j;
        int         lvl_m;
        int         w;
        logic [7:0] b;
        logic       quiet;

        vec[0] = '{dut: 0, data: 9'h0A5, bits: 16'({1'b1, 8'hA5, 1'b0}), len: 10, immediate: 1'b0};
        vec[1] = '{dut: 0, data: 9'h000, bits: 16'({1'b1, 8'h00, 1'b0}), len: 10, immediate: 1'b0};
        vec[2] = '{dut: 1, data: 9'h007, bits: 16'({1'b1, 1'b1, 8'h07, 1'b0}), len: 11, immediate: 1'b0};
        vec[3] = '{dut: 1, data: 9'h000, bits: 16'({1'b1, 1'b0, 8'h00, 1'b0}), len: 11, immediate: 1'b0};
        vec[4] = '{dut: 2, data: 9'h007, bits: 16'({1'b1, 1'b0, 8'h07, 1'b0}), len: 11, immediate: 1'b0};
        vec[5] = '{dut: 2, data: 9'h0FF, bits: 16'({1'b1, 1'b1, 8'hFF, 1'b0}), len: 11, immediate: 1'b0};
        vec[6] = '{dut: 3, data: 9'h000, bits: 16'({2'b11, 8'h00, 1'b0}), len: 11, immediate: 1'b0};
        vec[7] = '{dut: 3, data: 9'h0FF, bits: 16'({2'b11, 8'hFF, 1'b0}), len: 11, immediate: 1'b1};
        vec[8] = '{dut: 4, data: 9'h055, bits: 16'({1'b1, 1'b1, 7'h55, 1'b0}), len: 10, immediate: 1'b0};
        vec[9] = '{dut: 4, data: 9'h07F, bits: 16'({1'b1, 1'b0, 7'h7F, 1'b0}), len: 10, immediate: 1'b0};

        for (int d = 0; d < NDut; d++) begin
            vld[d] = 1'b0;
            din[d] = '0;
        end

        // Reset state of every instance.
        repeat (3) @(negedge sys_clk);
        for (int d = 0; d < NDut; d++) begin
            check($sformatf("dut%0d reset tx", d), 16'(txw[d]), 16'd1);
            check($sformatf("dut%0d reset busy", d), 16'(bsy[d]), 16'd0);
            check($sformatf("dut%0d reset in_ready", d), 16'(rdy[d]), 16'd1);
            check($sformatf("dut%0d reset fifo_level", d), 16'(lvl[d]), 16'd0);
        end
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Accept at edge N: still high after N and N+1, start bit after N+2.
        drive_write(0, 9'h0C3, 1'b1,
                    '{dut: 0, data: 9'h0C3, bits: 16'({1'b1, 8'hC3, 1'b0}), len: 10, immediate: 1'b1});
        drive_idle(0);
        check("latency tx after N", 16'(txw[0]), 16'd1);
        check("latency level after N", 16'(lvl[0]), 16'd1);
        @(negedge sys_clk);
        check("latency tx after N+1", 16'(txw[0]), 16'd1);
        check("latency level after N+1", 16'(lvl[0]), 16'd0);
        check_frames(1);
        wait_idle(0);

        // Table vectors; entries marked immediate are queued with the previous one.
        i = 0;
        while (i < NVec) begin
            j = i;
            drive_write(vec[j].dut, vec[j].data, 1'b1, vec[j]);
            while (j + 1 < NVec && vec[j + 1].immediate) begin
                j++;
                drive_write(vec[j].dut, vec[j].data, 1'b1, vec[j]);
            end
            drive_idle(vec[i].dut);
            check_frames(j - i + 1);
            wait_idle(vec[i].dut);
            i = j + 1;
        end

        // Six writes against a busy line: four fit, two are dropped.
        drive_write(0, 9'h0E7, 1'b1,
                    '{dut: 0, data: 9'h0E7, bits: 16'({1'b1, 8'hE7, 1'b0}), len: 10, immediate: 1'b0});
        fork
            check_frames(5);
            begin
                drive_idle(0);
                repeat (2) @(negedge sys_clk);
                lvl_m = 0;
                for (int k = 0; k < 6; k++) begin
                    b = 8'(8'h11 * (k + 1));
                    drive_write(0, {1'b0, b}, lvl_m < 4,
                                '{dut: 0, data: {1'b0, b}, bits: 16'({1'b1, b, 1'b0}), len: 10,
                                  immediate: 1'b1});
                    if (lvl_m < 4) lvl_m++;
                end
                drive_idle(0);
                check("burst fifo_level", 16'(lvl[0]), 16'd4);
                check("burst in_ready", 16'(rdy[0]), 16'd0);
            end
        join
        wait_idle(0);

        // Reset during the third data bit aborts the frame and flushes the queue.
        drive_write(0, 9'h03B, 1'b1,
                    '{dut: 0, data: 9'h03B, bits: 16'({1'b1, 8'h3B, 1'b0}), len: 10, immediate: 1'b0});
        drive_write(0, 9'h011, 1'b1,
                    '{dut: 0, data: 9'h011, bits: 16'({1'b1, 8'h11, 1'b0}), len: 10, immediate: 1'b0});
        drive_idle(0);
        w = 0;
        while (txw[0] !== 1'b0 && w < 20) begin
            @(negedge sys_clk);
            w++;
        end
        check("abort start seen", 16'(txw[0]), 16'd0);
        repeat (13) @(negedge sys_clk);
        check("abort third data bit", 16'(txw[0]), 16'd0);
        check("abort queued level", 16'(lvl[0]), 16'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("abort tx", 16'(txw[0]), 16'd1);
        check("abort fifo_level", 16'(lvl[0]), 16'd0);
        check("abort busy", 16'(bsy[0]), 16'd0);
        check("abort in_ready", 16'(rdy[0]), 16'd1);
        sys_rst = 1'b0;
        exp_q.delete();
        quiet = 1'b1;
        repeat (50) begin
            @(negedge sys_clk);
            if (txw[0] !== 1'b1) quiet = 1'b0;
        end
        check("discarded data stays off the line", 16'(quiet), 16'd1);
        drive_write(0, 9'h05A, 1'b1,
                    '{dut: 0, data: 9'h05A, bits: 16'({1'b1, 8'h5A, 1'b0}), len: 10, immediate: 1'b0});
        drive_idle(0);
        check_frames(1);
        wait_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_DIV, default 5208: sys_clk cycles per bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values 1..2.
REQ-005 Parameter FIFO_DEPTH, default 4: entries in the input FIFO; power of two, 2..64.
REQ-006 sys_clk  in  1  sole clock; all logic on the rising edge.
REQ-007 sys_rst  in  1  reset; synchronous, active-high.
REQ-008 in_data  in  DATA_BITS  byte to send; sampled when in_valid && in_ready.
REQ-009 in_valid  in  1  producer offers in_data.
REQ-010 in_ready  out  1  high when the FIFO is not full.
REQ-011 tx  out  1  serial line; idle high.
REQ-012 busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries currently held.

Function
REQ-014 Frame order: start bit (0), data LSB first, optional parity, STOP_BITS stop bits (1); each bit lasts exactly CLK_DIV cycles.
REQ-015 Odd parity makes the count of ones over data plus parity odd; even parity makes it even.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; all registered; tx is a registered output.
REQ-017 IDLE to START: when the FIFO is non-empty, pop the head into the shift register; tx goes low on the next edge.
REQ-018 START to DATA at bit end; DATA to PARITY (or STOP if PARITY = 0) after DATA_BITS bits; STOP to IDLE after STOP_BITS bits.
REQ-019 Baud counter: counts 0..CLK_DIV-1 only outside IDLE; wraps to 0 at each bit end; forced to 0 in IDLE.
REQ-020 Back-to-back: if the FIFO is non-empty at the end of the last stop bit, go directly from STOP to START (no idle cycle); tx stays 1 through that edge and then drops.
REQ-021 Latency: data accepted at edge N into an empty FIFO while IDLE gives a pop at N+1 and tx = 0 after edge N+2.
REQ-022 Push while full: the write is ignored and in_ready stays 0; no entry is overwritten.
REQ-023 Push and pop in the same cycle: both are performed and fifo_level is unchanged; when full, a simultaneous pop does not raise in_ready in that cycle.
REQ-024 in_data changes after acceptance do not affect a queued or in-flight frame.
REQ-025 fifo_level wraps neither up nor down; the read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 On sys_rst: tx = 1, busy = 0, in_ready = 1 on the next cycle, fifo_level = 0, FSM = IDLE, baud counter = 0, FIFO emptied.
REQ-027 Reset mid-frame aborts the frame immediately: tx returns to 1 after the reset edge and queued data is discarded.

Structure
REQ-028 Shared package uart_pkg: FSM state enum, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and a function computing the parity bit.
REQ-029 One sub-module, uart_sync_fifo (parametrised width/depth, show-ahead), instantiated once; FSM, baud counter and shifter live in uart_tx_cfg.

Verification (CLK_DIV = 4 in simulation)
REQ-030 Reset released, write 8'hA5, PARITY = 0 -> tx after edge N+2: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; busy falls afterwards.
REQ-031 PARITY = 2, write 8'h07 -> parity bit = 1; PARITY = 1, write 8'h07 -> parity bit = 0.
REQ-032 STOP_BITS = 2, write 8'h00 then 8'hFF back-to-back -> stop high for 8 cycles, then the second start bit with no extra idle cycles.
REQ-033 FIFO_DEPTH = 4, hold in_valid for 6 writes while the line is busy -> in_ready drops after 4 writes (fifo_level = 4, excess writes dropped), then 5 frames in write order.
REQ-034 sys_rst asserted during the 3rd data bit -> tx = 1 and fifo_level = 0 after the reset edge; the next write produces a complete, correct frame.
REQ-035 DATA_BITS = 7, PARITY = 1, write 7'h55 -> 7 data bits, parity = 1, frame length 10 bits (40 cycles).
